// File: rtl/pong_game_ctrl.sv
// Pong frame sequencer. On each vertical-blank tick it moves the paddle, then
// the ball, then resolves wall, paddle and floor collisions. All positions
// change only during blanking, so the renderer sees them stable for the
// whole active frame.
module pong_game_ctrl #(
    parameter int SCREEN_W     = 800,
    parameter int SCREEN_H     = 600,
    parameter int PADDLE_W     = 100,
    parameter int PADDLE_Y     = 560,
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_STEP  = 4,
    parameter int BALL_STEP    = 2,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       clock_100Mhz,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       right,
    input  logic       left,
    output logic [9:0] paddlePos,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [7:0] score,
    output logic       miss,
    output logic       busy
);

    localparam int CW = $clog2(SERVE_FRAMES + 1);

    // 11-bit constants keep every comparison free of 10-bit wrap
    localparam logic [10:0]        PAD_MAX  = 11'(SCREEN_W - PADDLE_W);
    localparam logic [10:0]        PSTEP    = 11'(PADDLE_STEP);
    localparam logic signed [10:0] BSTEP    = 11'(BALL_STEP);
    localparam logic signed [10:0] BSZ      = 11'(BALL_SIZE);
    localparam logic signed [10:0] PY       = 11'(PADDLE_Y);
    localparam logic signed [10:0] PW       = 11'(PADDLE_W);
    localparam logic signed [10:0] XMAX     = 11'(SCREEN_W - BALL_SIZE);
    localparam logic signed [10:0] YMAX     = 11'(SCREEN_H - BALL_SIZE);
    localparam logic [9:0]         PAD_RST  = 10'((SCREEN_W - PADDLE_W) / 2);
    localparam logic [9:0]         BX_RST   = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0]         BY_RST   = 10'((SCREEN_H - BALL_SIZE) / 2);

    typedef enum logic [2:0] {SERVE, WAIT, PADDLE, BALL, COLLIDE, MISS} state_t;

    state_t             state;
    logic [CW-1:0]      srv_cnt;
    logic               dx, dy;        // dx=1 right, dy=1 down
    logic signed [10:0] cx, cy, oy;    // candidate position and pre-move y

    logic [10:0]        pp_up;
    logic [9:0]         pad_nxt;
    logic signed [10:0] pp_s, bx_s, by_s;
    logic signed [10:0] nx, ny;
    logic               ndx, ndy, hit, do_miss;

    assign pp_s = signed'({1'b0, paddlePos});
    assign bx_s = signed'({1'b0, ball_x});
    assign by_s = signed'({1'b0, ball_y});
    assign pp_up = {1'b0, paddlePos} + PSTEP;

    // Paddle next position from buttons, clamped to the screen
    always_comb begin
        pad_nxt = paddlePos;
        if (right && !left)
            pad_nxt = (pp_up > PAD_MAX) ? PAD_MAX[9:0] : pp_up[9:0];
        else if (left && !right)
            pad_nxt = ({1'b0, paddlePos} < PSTEP) ? 10'd0 : 10'(pp_s - signed'(PSTEP));
    end

    // Collision resolution on the candidate position; axes are independent
    always_comb begin
        hit = dy && (cy + BSZ >= PY) && (oy + BSZ <= PY) &&
              (cx + BSZ > pp_s) && (cx < pp_s + PW);
        nx  = cx;
        ndx = dx;
        if (cx <= 0) begin
            nx  = '0;
            ndx = 1'b1;
        end else if (cx >= XMAX) begin
            nx  = XMAX;
            ndx = 1'b0;
        end
        ny  = cy;
        ndy = dy;
        if (cy <= 0) begin
            ny  = '0;
            ndy = 1'b1;
        end else if (hit) begin
            ny  = PY - BSZ;
            ndy = 1'b0;
        end
        do_miss = !hit && (cy >= YMAX);
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clock_100Mhz or negedge rst) begin
        if (!rst) begin
            state     <= SERVE;
            srv_cnt   <= '0;
            paddlePos <= PAD_RST;
            ball_x    <= BX_RST;
            ball_y    <= BY_RST;
            dx        <= 1'b1;
            dy        <= 1'b0;
            score     <= '0;
            miss      <= 1'b0;
            busy      <= 1'b0;
            cx        <= '0;
            cy        <= '0;
            oy        <= '0;
        end else begin
            miss <= 1'b0;
            case (state)
                SERVE: if (frame_tick) begin
                    paddlePos <= pad_nxt;
                    if (srv_cnt == CW'(SERVE_FRAMES - 1)) begin
                        srv_cnt <= '0;
                        state   <= WAIT;
                    end else begin
                        srv_cnt <= srv_cnt + 1'b1;
                    end
                end
                WAIT: if (frame_tick) begin
                    busy  <= 1'b1;
                    state <= PADDLE;
                end
                PADDLE: begin
                    paddlePos <= pad_nxt;
                    state     <= BALL;
                end
                BALL: begin
                    cx    <= dx ? bx_s + BSTEP : bx_s - BSTEP;
                    cy    <= dy ? by_s + BSTEP : by_s - BSTEP;
                    oy    <= by_s;
                    state <= COLLIDE;
                end
                COLLIDE: begin
                    ball_x <= 10'(nx);
                    ball_y <= 10'(ny);
                    dx     <= ndx;
                    dy     <= ndy;
                    if (hit && score != 8'hFF)
                        score <= score + 8'd1;
                    if (do_miss) begin
                        miss  <= 1'b1;
                        state <= MISS;
                    end else begin
                        busy  <= 1'b0;
                        state <= WAIT;
                    end
                end
                MISS: begin
                    ball_x  <= BX_RST;
                    ball_y  <= BY_RST;
                    dx      <= 1'b1;
                    dy      <= 1'b0;
                    busy    <= 1'b0;
                    srv_cnt <= '0;
                    state   <= SERVE;
                end
                default: state <= SERVE;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: serve hold, paddle limits, wall and
// paddle bounces, floor miss and asynchronous reset mid-sequence. The ball
// follows its natural trajectory from reset; expected coordinates are
// hand-derived from that path.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       rst, frame_tick, right, left;
    logic [9:0] paddlePos, ball_x, ball_y;
    logic [7:0] score;
    logic       miss, busy;

    int n_chk = 0;
    int n_err = 0;
    int t = 0;
    int miss_cnt = 0;

    pong_game_ctrl dut (
        .clock_100Mhz(clk),
        .rst(rst),
        .frame_tick(frame_tick),
        .right(right),
        .left(left),
        .paddlePos(paddlePos),
        .ball_x(ball_x),
        .ball_y(ball_y),
        .score(score),
        .miss(miss),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (miss === 1'b1) miss_cnt++;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (tick %0d)", tag, got, exp, t);
        end
    endtask

    task automatic tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        repeat (6) @(negedge clk);
        t++;
    endtask

    // Second pulse lands while the sequence is still running
    task automatic tick_double();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        chk("busy_during_seq", int'(busy), 1);
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        repeat (6) @(negedge clk);
        chk("busy_after_seq", int'(busy), 0);
        t++;
    endtask

    task automatic ticks_to(input int target);
        while (t < target) tick();
    endtask

    task automatic chk_ball(input string tag, input int x, input int y);
        chk({tag, "_x"}, int'(ball_x), x);
        chk({tag, "_y"}, int'(ball_y), y);
    endtask

    initial begin
        rst = 1'b0; frame_tick = 1'b0; right = 1'b0; left = 1'b0;
        #23;
        chk("rst_paddle", int'(paddlePos), 350);
        chk_ball("rst_ball", 396, 296);
        chk("rst_score", int'(score), 0);
        chk("rst_miss", int'(miss), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk) rst = 1'b1;

        // Serve: paddle moves, ball held for 60 ticks
        right = 1'b1;
        ticks_to(60);
        chk("serve_paddle", int'(paddlePos), 590);
        chk_ball("serve_hold", 396, 296);
        tick_double();
        chk_ball("first_move", 398, 294);

        ticks_to(87);
        chk("pad_87", int'(paddlePos), 698);
        ticks_to(88);
        chk("pad_sat", int'(paddlePos), 700);
        ticks_to(100);
        chk("pad_sat_hold", int'(paddlePos), 700);

        right = 1'b0; left = 1'b1;
        ticks_to(150);
        chk("pad_left", int'(paddlePos), 500);
        right = 1'b1;
        ticks_to(160);
        chk("pad_both", int'(paddlePos), 500);
        right = 1'b0;

        ticks_to(208);
        chk_ball("top_wall", 692, 0);
        ticks_to(257);
        chk_ball("pre_right", 790, 98);
        ticks_to(258);
        chk_ball("right_wall", 792, 100);
        ticks_to(259);
        chk_ball("after_right", 790, 102);

        ticks_to(310);
        chk("pad_zero", int'(paddlePos), 0);
        left = 1'b0;

        // First descent misses the paddle parked at 0
        ticks_to(484);
        chk_ball("pass_paddle", 340, 552);
        chk("no_hit_score", int'(score), 0);
        ticks_to(503);
        chk_ball("pre_miss", 302, 590);
        chk("no_miss_yet", miss_cnt, 0);
        ticks_to(504);
        chk("miss_pulse", miss_cnt, 1);
        chk_ball("miss_centre", 396, 296);
        chk("miss_score", int'(score), 0);

        // Second serve, paddle moved to 300 to catch the next descent
        right = 1'b1;
        ticks_to(564);
        chk_ball("reserve_hold", 396, 296);
        ticks_to(565);
        chk_ball("reserve_move", 398, 294);
        ticks_to(579);
        chk("pad_300", int'(paddlePos), 300);
        right = 1'b0;

        ticks_to(987);
        chk_ball("pre_hit", 342, 550);
        ticks_to(988);
        chk_ball("paddle_hit", 340, 552);
        chk("hit_score", int'(score), 1);
        ticks_to(989);
        chk_ball("after_hit", 338, 550);
        chk("miss_total", miss_cnt, 1);

        // Asynchronous reset while the ball update is in flight
        @(negedge clk) frame_tick = 1'b1;
        @(posedge clk);
        @(negedge clk) frame_tick = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_paddle", int'(paddlePos), 350);
        chk_ball("arst_ball", 396, 296);
        chk("arst_score", int'(score), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_miss", int'(miss), 0);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
